// File: rtl/q6_trace_pkg.sv
// Shared definitions for the q6 trace decoder: state codes, tracker states,
// the illegal-code check and the legal-successor function of the q6 FSM.
package q6_trace_pkg;

  localparam logic [2:0] ST_A = 3'b000;
  localparam logic [2:0] ST_B = 3'b001;
  localparam logic [2:0] ST_C = 3'b010;
  localparam logic [2:0] ST_D = 3'b011;
  localparam logic [2:0] ST_E = 3'b100;
  localparam logic [2:0] ST_F = 3'b101;

  typedef enum logic [1:0] {
    NOSYNC = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2
  } trk_state_e;

  // Codes 110 and 111 never appear on a healthy q6 FSM.
  function automatic logic q6_is_illegal(input logic [2:0] y);
    return y[2] & y[1];
  endfunction

  function automatic logic [2:0] q6_next(input logic [2:0] y, input logic w);
    logic [2:0] nxt;
    nxt = ST_A;
    case (y)
      ST_A:    nxt = w ? ST_A : ST_B;
      ST_B:    nxt = w ? ST_D : ST_C;
      ST_C:    nxt = w ? ST_D : ST_E;
      ST_D:    nxt = w ? ST_A : ST_F;
      ST_E:    nxt = w ? ST_D : ST_E;
      ST_F:    nxt = w ? ST_D : ST_C;
      default: nxt = ST_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/q6_trace_decoder_next_state.sv
// Combinational successor check: is cur reachable from prev in one step, and
// which w value produced it.
module q6_next_state
  import q6_trace_pkg::*;
(
  input  logic [2:0] prev_i,
  input  logic [2:0] cur_i,
  output logic       legal_succ_o,
  output logic       w_dec_o
);

  logic [2:0] succ0;
  logic [2:0] succ1;

  assign succ0 = q6_next(prev_i, 1'b0);
  assign succ1 = q6_next(prev_i, 1'b1);

  // The two successors always differ, so matching succ1 identifies w=1.
  assign legal_succ_o = (cur_i == succ0) || (cur_i == succ1);
  assign w_dec_o      = (cur_i == succ1);

endmodule

// File: rtl/q6_trace_decoder.sv
// q6 state-trace decoder: recovers w, z, lock status and error pulses from the
// FSM's state trace. Q6_ERR_COUNT_EN builds the saturating error counter.
module q6_trace_decoder
  import q6_trace_pkg::*;
#(
  parameter int RELOCK_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [2:0]       y_in,
  input  logic             y_valid,
  input  logic             err_clr,
  output logic             w_out,
  output logic             w_valid,
  output logic             z_out,
  output logic             locked,
  output logic             err_illegal_code,
  output logic             err_bad_transition,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0] RELOCK_L = 4'(RELOCK_LEN);

  trk_state_e state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [3:0] run_q, run_d;
  logic       w_out_q, w_out_d;
  logic       w_valid_q, w_valid_d;
  logic       eic_q, eic_d;
  logic       ebt_q, ebt_d;
  logic       legal_succ;
  logic       w_dec;
  logic [3:0] run_inc;

  q6_next_state u_next (
    .prev_i       (prev_q),
    .cur_i        (y_in),
    .legal_succ_o (legal_succ),
    .w_dec_o      (w_dec)
  );

  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    w_out_d   = w_out_q;
    w_valid_d = 1'b0;
    eic_d     = 1'b0;
    ebt_d     = 1'b0;
    if (y_valid) begin
      if (q6_is_illegal(y_in)) begin
        eic_d   = 1'b1;
        state_d = NOSYNC;
        run_d   = 4'd0;
      end else if (state_q == NOSYNC) begin
        prev_d  = y_in;
        run_d   = 4'd0;
        state_d = ACQ;
      end else if (legal_succ) begin
        w_valid_d = 1'b1;
        w_out_d   = w_dec;
        prev_d    = y_in;
        if (state_q == ACQ) begin
          run_d = run_inc;
          if (run_inc == RELOCK_L) state_d = LOCK;
        end
      end else begin
        // A legal code off the expected path: resynchronise on it.
        ebt_d   = 1'b1;
        prev_d  = y_in;
        run_d   = 4'd0;
        state_d = ACQ;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= NOSYNC;
      prev_q    <= ST_A;
      run_q     <= 4'd0;
      w_out_q   <= 1'b0;
      w_valid_q <= 1'b0;
      eic_q     <= 1'b0;
      ebt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      w_out_q   <= w_out_d;
      w_valid_q <= w_valid_d;
      eic_q     <= eic_d;
      ebt_q     <= ebt_d;
    end
  end

  assign w_out              = w_out_q;
  assign w_valid            = w_valid_q;
  assign err_illegal_code   = eic_q;
  assign err_bad_transition = ebt_q;
  assign locked             = (state_q == LOCK);
  assign z_out              = (state_q != NOSYNC) && ((prev_q == ST_E) || (prev_q == ST_F));

`ifdef Q6_ERR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_evt;

  assign err_evt = eic_d | ebt_d;

  // A clear coinciding with an error leaves exactly that error counted.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)                       cnt_d = err_evt ? CNT_W'(1) : '0;
    else if (err_evt && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_q6_trace_decoder.sv
// Directed bench for q6_trace_decoder (RELOCK_LEN=2, CNT_W=2); counter
// expectations follow Q6_ERR_COUNT_EN.
module tb_q6_trace_decoder;

`ifdef Q6_ERR_COUNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic [2:0] y_in = 3'b000;
  logic       y_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       w_out, w_valid, z_out, locked, err_illegal_code, err_bad_transition;
  logic [1:0] err_count;

  int checks = 0;
  int errors = 0;

  q6_trace_decoder #(.RELOCK_LEN(2), .CNT_W(2)) dut (
    .clk                (clk),
    .areset             (areset),
    .y_in               (y_in),
    .y_valid            (y_valid),
    .err_clr            (err_clr),
    .w_out              (w_out),
    .w_valid            (w_valid),
    .z_out              (z_out),
    .locked             (locked),
    .err_illegal_code   (err_illegal_code),
    .err_bad_transition (err_bad_transition),
    .err_count          (err_count)
  );

  always #5 clk = ~clk;

  // Output vector: {w_valid, w_out, z_out, locked, err_illegal_code, err_bad_transition}
  function automatic logic [5:0] obs();
    return {w_valid, w_out, z_out, locked, err_illegal_code, err_bad_transition};
  endfunction

  function automatic logic [1:0] ecnt(input logic [1:0] v);
    return EN ? v : 2'd0;
  endfunction

  // Apply one cycle of inputs at negedge; outputs settle just after the next posedge.
  task automatic drive(input logic v, input logic [2:0] y, input logic clr);
    @(negedge clk);
    y_valid = v;
    y_in    = y;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    #3;
    checks++;
    if ({obs(), err_count} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", {obs(), err_count}, 8'd0);
    end
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic test_decode();
    logic [2:0] ys[5] = '{3'b000, 3'b001, 3'b011, 3'b000, 3'b000};
    logic [5:0] ev[5] = '{6'b000000, 6'b100000, 6'b110100, 6'b110100, 6'b110100};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ys[i], 1'b0);
      checks++;
      if (obs() !== ev[i]) begin
        errors++;
        $display("FAIL decode[%0d] got %b exp %b", i, obs(), ev[i]);
      end
    end
  endtask

  task automatic test_bad_transition();
    logic [2:0] ys[4] = '{3'b001, 3'b011, 3'b101, 3'b100};
    logic [5:0] ev[4] = '{6'b100100, 6'b110100, 6'b101100, 6'b001001};
    logic [1:0] ec[4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ys[i], 1'b0);
      checks++;
      if (obs() !== ev[i] || err_count !== ecnt(ec[i])) begin
        errors++;
        $display("FAIL badtr[%0d] got %b/%0d exp %b/%0d", i, obs(), err_count, ev[i], ecnt(ec[i]));
      end
    end
    drive(1'b0, 3'b000, 1'b0);
    checks++;
    if (obs() !== 6'b001000 || err_count !== ecnt(2'd1)) begin
      errors++;
      $display("FAIL badtr_idle got %b/%0d exp %b/%0d", obs(), err_count, 6'b001000, ecnt(2'd1));
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ys[4] = '{3'b011, 3'b101, 3'b111, 3'b010};
    logic [5:0] ev[4] = '{6'b110000, 6'b101100, 6'b000010, 6'b000000};
    logic [1:0] ec[4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ys[i], 1'b0);
      checks++;
      if (obs() !== ev[i] || err_count !== ecnt(ec[i])) begin
        errors++;
        $display("FAIL illegal[%0d] got %b/%0d exp %b/%0d", i, obs(), err_count, ev[i], ecnt(ec[i]));
      end
    end
  endtask

  task automatic test_err_count();
    logic [1:0] ec[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b0, 3'b000, 1'b1);
    checks++;
    if (obs() !== 6'b000000 || err_count !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clr0 got %b/%0d exp %b/%0d", obs(), err_count, 6'b000000, 2'd0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i % 2 == 0) ? 3'b110 : 3'b111, 1'b0);
      checks++;
      if (obs() !== 6'b000010 || err_count !== ecnt(ec[i])) begin
        errors++;
        $display("FAIL cnt_sat[%0d] got %b/%0d exp %b/%0d", i, obs(), err_count, 6'b000010, ecnt(ec[i]));
      end
    end
    drive(1'b1, 3'b111, 1'b1);
    checks++;
    if (obs() !== 6'b000010 || err_count !== ecnt(2'd1)) begin
      errors++;
      $display("FAIL cnt_clr_err got %b/%0d exp %b/%0d", obs(), err_count, 6'b000010, ecnt(2'd1));
    end
    drive(1'b0, 3'b000, 1'b1);
    checks++;
    if (obs() !== 6'b000000 || err_count !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clr_alone got %b/%0d exp %b/%0d", obs(), err_count, 6'b000000, 2'd0);
    end
  endtask

  task automatic test_gaps_and_reset();
    logic [2:0] ys[4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    logic [5:0] ev[4] = '{6'b000000, 6'b100000, 6'b100100, 6'b101100};
    logic [5:0] gv[4] = '{6'b000000, 6'b000000, 6'b000100, 6'b001100};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ys[i], 1'b0);
      checks++;
      if (obs() !== ev[i]) begin
        errors++;
        $display("FAIL gap_sample[%0d] got %b exp %b", i, obs(), ev[i]);
      end
      for (int g = 0; g < 2; g++) begin
        drive(1'b0, 3'b111, 1'b0);
        checks++;
        if (obs() !== gv[i]) begin
          errors++;
          $display("FAIL gap_idle[%0d.%0d] got %b exp %b", i, g, obs(), gv[i]);
        end
      end
    end
    areset = 1'b1;
    #1;
    checks++;
    if ({obs(), err_count} !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", {obs(), err_count}, 8'd0);
    end
    @(negedge clk);
    areset = 1'b0;
    drive(1'b1, 3'b010, 1'b0);
    checks++;
    if (obs() !== 6'b000000) begin
      errors++;
      $display("FAIL reacq_first got %b exp %b", obs(), 6'b000000);
    end
    drive(1'b1, 3'b100, 1'b0);
    checks++;
    if (obs() !== 6'b101000) begin
      errors++;
      $display("FAIL reacq_second got %b exp %b", obs(), 6'b101000);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_bad_transition();
    test_illegal();
    test_err_count();
    test_gaps_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
